// File: rtl/circular_right_shift_amount_detector.sv
// Sequential rotation decoder: finds the smallest S with rotr(a, S) == b,
// testing one candidate shift per cycle behind valid/ready handshakes.
module circular_right_shift_amount_detector #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         found,
  output logic [W-1:0] shift
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state;
  logic [N-1:0] cand;
  logic [N-1:0] ref_word;
  logic [W-1:0] cnt;

  assign in_ready = (state == IDLE);

  // S = 0 is compared before any rotation, so periodic words report the smallest amount
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= '0;
      ref_word  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      found     <= 1'b0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cand     <= a;
            ref_word <= b;
            cnt      <= '0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (cand == ref_word) begin
            found     <= 1'b1;
            shift     <= cnt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == LAST) begin
            found     <= 1'b0;
            shift     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cand <= {cand[0], cand[N-1:1]};
            cnt  <= cnt + W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circular_right_shift_amount_detector.sv
// Scoreboard bench: lane 0 drives an N=8 detector, lane 1 an N=5 detector,
// sharing one clock and one active-low reset.
module tb_circular_right_shift_amount_detector;

  typedef struct {
    int found;
    int shift;
    int lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid_s [2];
  logic       in_ready_s [2];
  logic       out_valid_s[2];
  logic       out_ready_s[2];
  logic       found_s    [2];
  logic [2:0] shift_s    [2];
  logic [7:0] a0, b0;
  logic [4:0] a1, b1;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int pending_acc[2];
  bit prev_valid[2];
  bit chk_next[2];
  bit end_check = 0;
  bit end_done = 0;

  circular_right_shift_amount_detector #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a0), .b(b0),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .found(found_s[0]), .shift(shift_s[0])
  );

  circular_right_shift_amount_detector #(.N(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a1), .b(b1),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .found(found_s[1]), .shift(shift_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Bit-indexed reference rotation: y[i] = x[(i + s) mod n]
  function automatic logic [7:0] rotr(input logic [7:0] x, input int s, input int n);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < n; i++) y[i] = x[(i + s) % n];
    return y;
  endfunction

  function automatic int minShift(input logic [7:0] x, input logic [7:0] y, input int n);
    for (int s = 0; s < n; s++)
      if (rotr(x, s, n) == y) return s;
    return -1;
  endfunction

  function automatic int qsize(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int l);
    return (l == 0) ? q0[0] : q1[0];
  endfunction

  task automatic checkOutput(input string name, input int l, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL lane%0d %s: got %0d expected %0d (t=%0t)", l, name, act, req, $time);
    end
  endtask

  task automatic monitorLane(input int l);
    exp_t e;
    if (!rst) begin
      checkOutput("rst_in_ready", l, int'(in_ready_s[l]), 1);
      checkOutput("rst_out_valid", l, int'(out_valid_s[l]), 0);
      checkOutput("rst_found", l, int'(found_s[l]), 0);
      checkOutput("rst_shift", l, int'(shift_s[l]), 0);
      pending_acc[l] = -1;
      prev_valid[l]  = 1'b0;
      chk_next[l]    = 1'b0;
      if (l == 0) q0.delete(); else q1.delete();
      return;
    end
    if (chk_next[l]) begin
      checkOutput("in_ready_after_hs", l, int'(in_ready_s[l]), 1);
      checkOutput("out_valid_after_hs", l, int'(out_valid_s[l]), 0);
      chk_next[l] = 1'b0;
    end
    if (out_valid_s[l] && !prev_valid[l]) begin
      checkOutput("result_expected", l, int'(qsize(l) != 0), 1);
      if (qsize(l) != 0) begin
        e = qfront(l);
        checkOutput("found", l, int'(found_s[l]), e.found);
        checkOutput("shift", l, int'(shift_s[l]), e.shift);
        checkOutput("latency", l, edge_cnt - pending_acc[l], e.lat);
        checkOutput("in_ready_done", l, int'(in_ready_s[l]), 0);
      end
    end else if (out_valid_s[l] && !out_ready_s[l] && qsize(l) != 0) begin
      e = qfront(l);
      checkOutput("held_found", l, int'(found_s[l]), e.found);
      checkOutput("held_shift", l, int'(shift_s[l]), e.shift);
      checkOutput("held_in_ready", l, int'(in_ready_s[l]), 0);
    end
    if (out_valid_s[l] && out_ready_s[l] && qsize(l) != 0) begin
      if (l == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      chk_next[l] = 1'b1;
    end
    if (in_valid_s[l] && in_ready_s[l]) pending_acc[l] = edge_cnt + 1;
    prev_valid[l] = out_valid_s[l];
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) monitorLane(l);
    if (end_check && !end_done) begin
      checkOutput("drained", 0, qsize(0), 0);
      checkOutput("drained", 1, qsize(1), 0);
      end_done = 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic applyStimulus(input int l, input logic [7:0] av, input logic [7:0] bv,
                               input int ef, input int es, input bit push);
    int   guard;
    int   n;
    exp_t e;
    n = (l == 0) ? 8 : 5;
    guard = 0;
    while (!in_ready_s[l]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        $display("[TB] FAIL lane%0d accept_timeout: in_ready stayed 0", l);
        $fatal(1, "[TB] timeout");
      end
    end
    if (l == 0) begin a0 = av; b0 = bv; end
    else begin a1 = av[4:0]; b1 = bv[4:0]; end
    in_valid_s[l] = 1'b1;
    if (push) begin
      e.found = ef;
      e.shift = es;
      e.lat   = (ef != 0) ? es + 1 : n;
      if (l == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    in_valid_s[l] = 1'b0;
    if (l == 0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
    else begin a1 = 5'($urandom); b1 = 5'($urandom); end
  endtask

  task automatic waitOutValid(input int l);
    int guard;
    guard = 0;
    while (!out_valid_s[l]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        $display("[TB] FAIL lane%0d out_valid_timeout: out_valid stayed 0", l);
        $fatal(1, "[TB] timeout");
      end
    end
  endtask

  task automatic randomBurst(input int l, input int count);
    logic [7:0] av, bv, mask;
    int n, s;
    n = (l == 0) ? 8 : 5;
    mask = (l == 0) ? 8'hFF : 8'h1F;
    for (int k = 0; k < count; k++) begin
      av = 8'($urandom) & mask;
      s  = $urandom_range(0, n - 1);
      bv = rotr(av, s, n);
      applyStimulus(l, av, bv, 1, minShift(av, bv, n), 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_valid_s[l]  = 1'b0;
      out_ready_s[l] = 1'b1;
      pending_acc[l] = -1;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 8'hB1, 8'h36, 1, 3, 1);
    applyStimulus(0, 8'h55, 8'h55, 1, 0, 1);
    applyStimulus(0, 8'h55, 8'hAA, 1, 1, 1);
    applyStimulus(0, 8'h01, 8'h03, 0, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 1, 0, 1);
    applyStimulus(1, 8'h03, 8'h18, 1, 2, 1);
    applyStimulus(1, 8'h01, 8'h03, 0, 0, 1);

    // Stall the result; the new request offered meanwhile must be ignored
    out_ready_s[0] = 1'b0;
    applyStimulus(0, 8'hB1, 8'h36, 1, 3, 1);
    waitOutValid(0);
    repeat (5) begin
      in_valid_s[0] = 1'b1;
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a search; nothing may emerge afterwards
    applyStimulus(0, 8'h01, 8'h03, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    randomBurst(0, 10);
    randomBurst(1, 10);

    repeat (20) @(posedge clk);
    end_check = 1'b1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
